// File: rtl/sfft_pkg.sv
// Shared definitions for the sFFT decimating input buffer.
// Provides the FSM state type, a constant clog2, and helpers that derive the
// frame/phase geometry (NFFT, P, PHASE_LEN, BUF_DEPTH) from the block parameters.
package sfft_pkg;

  typedef enum logic [0:0] {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int unsigned nfft_of(input int unsigned size_buffer);
    return 32'd1 << size_buffer;
  endfunction

  function automatic int unsigned phases_of(input int unsigned log2_phases);
    return 32'd1 << log2_phases;
  endfunction

  function automatic int unsigned phase_len_of(input int unsigned size_buffer,
                                               input int unsigned log2_phases);
    return 32'd1 << (size_buffer - log2_phases);
  endfunction

  // Phases 1..P-1 are buffered; phase 0 never touches the memory.
  function automatic int unsigned buf_depth_of(input int unsigned size_buffer,
                                               input int unsigned log2_phases);
    return nfft_of(size_buffer) - phase_len_of(size_buffer, log2_phases);
  endfunction

endpackage

// File: rtl/sfft_dp_buffer.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Ports:
//   i_clk      clock
//   i_wr_en    write enable
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_en    read enable; o_rd_data updates on the next rising edge
//   i_rd_addr  read address
//   o_rd_data  registered read data (holds when i_rd_en is low)
module sfft_dp_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array carries no reset; contents are always written before read.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: rtl/decimate_buffer_to_sfft.sv
// Decimating input buffer for the streaming FFT.
// Splits each NFFT-sample frame into P = 2^LOG2_PHASES phases (sample n goes to
// phase n mod P). Phase 0 is forwarded with zero latency while the frame loads;
// phases 1..P-1 are stored and replayed in phase order on sFFT request.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_in_data_i/q, i_valid    input sample stream, accepted when i_valid & o_ready
//   o_ready                   high while loading, low while draining
//   i_fft_wayt_data           sFFT read request (only honoured while draining)
//   o_out_data_i/q            output sample
//   o_outvalid, o_phase       output qualifier and phase index of the sample
//   o_frame_done              one-cycle pulse after the last sample of a frame
//   o_overflow                sticky: input offered while not ready
module decimate_buffer_to_sfft
  import sfft_pkg::*;
#(
  parameter  int unsigned SIZE_BUFFER   = 4,
  parameter  int unsigned DATA_FFT_SIZE = 16,
  parameter  int unsigned LOG2_PHASES   = 1,
  localparam int unsigned PW            = (LOG2_PHASES > 0) ? LOG2_PHASES : 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [DATA_FFT_SIZE-1:0] i_in_data_i,
  input  logic [DATA_FFT_SIZE-1:0] i_in_data_q,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_fft_wayt_data,
  output logic [DATA_FFT_SIZE-1:0] o_out_data_i,
  output logic [DATA_FFT_SIZE-1:0] o_out_data_q,
  output logic                     o_outvalid,
  output logic [PW-1:0]            o_phase,
  output logic                     o_frame_done,
  output logic                     o_overflow
);

  localparam int unsigned NFFT      = nfft_of(SIZE_BUFFER);
  localparam int unsigned P         = phases_of(LOG2_PHASES);
  localparam int unsigned PHASE_LEN = phase_len_of(SIZE_BUFFER, LOG2_PHASES);
  localparam int unsigned PL_LOG2   = SIZE_BUFFER - LOG2_PHASES;
  localparam int unsigned BUF_DEPTH = buf_depth_of(SIZE_BUFFER, LOG2_PHASES);
  localparam int unsigned MEM_DEPTH = (BUF_DEPTH > 0) ? BUF_DEPTH : 1;
  localparam int unsigned AW        = (MEM_DEPTH > 1) ? clog2(MEM_DEPTH) : 1;
  localparam int unsigned CW        = SIZE_BUFFER;
  localparam int unsigned SW        = 2 * DATA_FFT_SIZE;

  state_e          state_q;
  logic [CW-1:0]   n_q;
  logic [AW-1:0]   r_q;
  logic            rd_valid_q;
  logic            rd_last_q;
  logic [PW-1:0]   rd_phase_q;
  logic            frame_done_q;
  logic            overflow_q;

  logic            accept;
  logic            fwd;
  logic            wr_en;
  logic            rd_en;
  logic [PW-1:0]   phase_in;
  logic [AW-1:0]   wr_addr;
  logic [SW-1:0]   rd_data;

  // Input handshake and phase classification of the current sample.
  assign o_ready  = (state_q == ST_LOAD);
  assign accept   = i_valid & o_ready;
  assign phase_in = PW'(n_q & CW'(P - 1));
  assign fwd      = accept & (phase_in == '0);
  assign wr_en    = accept & (phase_in != '0);
  assign rd_en    = (state_q == ST_DRAIN) & i_fft_wayt_data;

  // Each buffered phase occupies a contiguous PHASE_LEN block, so a linear
  // read counter replays phase 1, then phase 2, and so on.
  assign wr_addr = AW'((32'(phase_in) - 32'd1) * PHASE_LEN + 32'(n_q >> LOG2_PHASES));

  if (P > 1) begin : g_buf
    sfft_dp_buffer #(
      .DEPTH  (MEM_DEPTH),
      .WIDTH  (SW),
      .ADDR_W (AW)
    ) u_buf (
      .i_clk     (i_clk),
      .i_wr_en   (wr_en),
      .i_wr_addr (wr_addr),
      .i_wr_data ({i_in_data_i, i_in_data_q}),
      .i_rd_en   (rd_en),
      .i_rd_addr (r_q),
      .o_rd_data (rd_data)
    );
  end else begin : g_bypass
    assign rd_data = '0;
  end

  // Output mux. The forwarded phase-0 path has priority: in the single cycle
  // where the last drained sample is shown, a newly accepted phase-0 sample
  // would take the output.
  assign o_outvalid   = fwd | rd_valid_q;
  assign o_out_data_i = fwd ? i_in_data_i
                      : (rd_valid_q ? rd_data[SW-1 -: DATA_FFT_SIZE] : '0);
  assign o_out_data_q = fwd ? i_in_data_q
                      : (rd_valid_q ? rd_data[DATA_FFT_SIZE-1:0] : '0);
  assign o_phase      = (rd_valid_q && !fwd) ? rd_phase_q : '0;
  assign o_frame_done = frame_done_q;
  assign o_overflow   = overflow_q;

  // FSM, counters and flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_LOAD;
      n_q          <= '0;
      r_q          <= '0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_phase_q   <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      // Pulse follows the cycle that showed the final drained sample.
      frame_done_q <= rd_valid_q & rd_last_q;

      if (i_valid && !o_ready) overflow_q <= 1'b1;
      if (accept) n_q <= n_q + CW'(1);

      case (state_q)
        ST_LOAD: begin
          if (accept && (n_q == CW'(NFFT - 1))) begin
            if (P == 1) frame_done_q <= 1'b1;
            else        state_q      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (i_fft_wayt_data) begin
            rd_valid_q <= 1'b1;
            rd_phase_q <= PW'(r_q >> PL_LOG2) + PW'(1);
            if (r_q == AW'(MEM_DEPTH - 1)) begin
              r_q       <= '0;
              rd_last_q <= 1'b1;
              state_q   <= ST_LOAD;
            end else begin
              r_q <= r_q + AW'(1);
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_decimate_buffer_to_sfft.sv
// Self-checking bench: three instances (P=2, P=4, P=1) driven one at a time
// against a queue-based frame model.
module tb_decimate_buffer_to_sfft;

  localparam int unsigned DW   = 16;
  localparam int unsigned NFFT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          valid    [3];
  logic          req      [3];
  logic [DW-1:0] din_i    [3];
  logic [DW-1:0] din_q    [3];
  logic [DW-1:0] dout_i   [3];
  logic [DW-1:0] dout_q   [3];
  logic          ready    [3];
  logic          outvalid [3];
  logic          done     [3];
  logic          ovf      [3];
  logic [0:0]    ph_p2;
  logic [1:0]    ph_p4;
  logic [0:0]    ph_p1;

  decimate_buffer_to_sfft #(.SIZE_BUFFER(4), .DATA_FFT_SIZE(DW), .LOG2_PHASES(1)) u_p2 (
    .i_clk(clk), .i_reset(rst), .i_in_data_i(din_i[0]), .i_in_data_q(din_q[0]),
    .i_valid(valid[0]), .o_ready(ready[0]), .i_fft_wayt_data(req[0]),
    .o_out_data_i(dout_i[0]), .o_out_data_q(dout_q[0]), .o_outvalid(outvalid[0]),
    .o_phase(ph_p2), .o_frame_done(done[0]), .o_overflow(ovf[0]));

  decimate_buffer_to_sfft #(.SIZE_BUFFER(4), .DATA_FFT_SIZE(DW), .LOG2_PHASES(2)) u_p4 (
    .i_clk(clk), .i_reset(rst), .i_in_data_i(din_i[1]), .i_in_data_q(din_q[1]),
    .i_valid(valid[1]), .o_ready(ready[1]), .i_fft_wayt_data(req[1]),
    .o_out_data_i(dout_i[1]), .o_out_data_q(dout_q[1]), .o_outvalid(outvalid[1]),
    .o_phase(ph_p4), .o_frame_done(done[1]), .o_overflow(ovf[1]));

  decimate_buffer_to_sfft #(.SIZE_BUFFER(4), .DATA_FFT_SIZE(DW), .LOG2_PHASES(0)) u_p1 (
    .i_clk(clk), .i_reset(rst), .i_in_data_i(din_i[2]), .i_in_data_q(din_q[2]),
    .i_valid(valid[2]), .o_ready(ready[2]), .i_fft_wayt_data(req[2]),
    .o_out_data_i(dout_i[2]), .o_out_data_q(dout_q[2]), .o_outvalid(outvalid[2]),
    .o_phase(ph_p1), .o_frame_done(done[2]), .o_overflow(ovf[2]));

  int errors = 0;
  int checks = 0;
  int cur    = 0;
  int P      = 2;
  int rl_cnt = 0;
  int dn_cnt = 0;
  int drained_seen = 0;

  // Reference model: frame contents and the expected replay order.
  int          n_acc;
  int          drain_left;
  logic [31:0] frame [NFFT];
  logic [31:0] bufq [$];
  int          phq [$];
  logic        pend_v;
  logic        pend_last;
  logic [31:0] pend_s;
  int          pend_ph;
  logic        done_exp;
  logic        ovf_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut=%0d got=%0h exp=%0h t=%0t", tag, cur, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_phase();
    case (cur)
      0:       return 32'(ph_p2);
      1:       return 32'(ph_p4);
      default: return 32'(ph_p1);
    endcase
  endfunction

  task automatic model_reset();
    n_acc      = 0;
    drain_left = 0;
    bufq.delete();
    phq.delete();
    pend_v     = 1'b0;
    pend_last  = 1'b0;
    pend_s     = '0;
    pend_ph    = 0;
    done_exp   = 1'b0;
    ovf_exp    = 1'b0;
  endtask

  task automatic set_dut(input int idx);
    valid[cur] = 1'b0;
    req[cur]   = 1'b0;
    cur = idx;
    case (idx)
      0:       P = 2;
      1:       P = 4;
      default: P = 1;
    endcase
  endtask

  // One clock: drive, check against the model, then advance the model.
  task automatic cyc(input logic v, input logic [DW-1:0] di, input logic [DW-1:0] dq,
                     input logic rq, input logic r);
    logic        rdy_e, acc, fwd, ov_e, dn_next;
    logic [31:0] od_e;
    int          ph_e;
    @(posedge clk);
    #1;
    rst        = r;
    valid[cur] = v;
    din_i[cur] = di;
    din_q[cur] = dq;
    req[cur]   = rq;
    @(negedge clk);
    rdy_e = (P == 1) || (drain_left == 0);
    acc   = v && rdy_e;
    fwd   = acc && ((n_acc % P) == 0);
    if (!r) begin
      if (!ready[cur]) rl_cnt++;
      if (done[cur])   dn_cnt++;
      check_val("ready", 32'(ready[cur]), 32'(rdy_e));
      ov_e = fwd || pend_v;
      check_val("outvalid", 32'(outvalid[cur]), 32'(ov_e));
      if (ov_e) begin
        od_e = fwd ? {di, dq} : pend_s;
        ph_e = fwd ? 0 : pend_ph;
        check_val("data_i", 32'(dout_i[cur]), 32'(od_e[31:16]));
        check_val("data_q", 32'(dout_q[cur]), 32'(od_e[15:0]));
        check_val("phase", get_phase(), 32'(ph_e));
        if (!fwd) drained_seen++;
      end
      check_val("frame_done", 32'(done[cur]), 32'(done_exp));
      check_val("overflow", 32'(ovf[cur]), 32'(ovf_exp));
    end
    if (r) begin
      model_reset();
    end else begin
      dn_next = pend_v && pend_last;
      if (drain_left > 0 && rq) begin
        pend_s     = bufq.pop_front();
        pend_ph    = phq.pop_front();
        pend_v     = 1'b1;
        drain_left = drain_left - 1;
        pend_last  = (drain_left == 0);
      end else begin
        pend_v    = 1'b0;
        pend_last = 1'b0;
      end
      if (v && !rdy_e) ovf_exp = 1'b1;
      if (acc) begin
        frame[n_acc] = {di, dq};
        if (n_acc == NFFT - 1) begin
          n_acc = 0;
          if (P == 1) begin
            dn_next = 1'b1;
          end else begin
            for (int p = 1; p < P; p++) begin
              for (int k = 0; k < NFFT / P; k++) begin
                bufq.push_back(frame[k * P + p]);
                phq.push_back(p);
              end
            end
            drain_left = NFFT - NFFT / P;
          end
        end else begin
          n_acc++;
        end
      end
      done_exp = dn_next;
    end
  endtask

  // Streams nfr frames, then idles a few cycles so the frame-done pulse shows.
  // req_mode: 0 constant request, 1 alternating, 2 random.
  task automatic run_frames(input int nfr, input bit ramp, input logic [DW-1:0] base,
                            input int req_mode, input int dens, input bit hold);
    int            sent, guard;
    logic          tog, v, rq, rdy_m;
    logic [DW-1:0] di, dq;
    sent  = 0;
    guard = 0;
    tog   = 1'b1;
    while ((sent < nfr * NFFT || drain_left > 0 || pend_v) && guard < 1000) begin
      rdy_m = (P == 1) || (drain_left == 0);
      v  = (sent < nfr * NFFT) && rdy_m && !pend_v && ($urandom_range(0, 99) < dens);
      if (hold && drain_left > 0) v = 1'b1;
      di = ramp ? DW'(32'(base) + sent) : DW'($urandom);
      dq = ramp ? ~di : DW'($urandom);
      case (req_mode)
        0:       rq = 1'b1;
        1:       rq = tog;
        default: rq = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      if (v && rdy_m) sent++;
      cyc(v, di, dq, rq, 1'b0);
      guard++;
    end
    check_val("frame_timeout", 32'(guard >= 1000), 32'd0);
    repeat (3) cyc(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0; req[i] = 1'b0; din_i[i] = '0; din_q[i] = '0;
    end
    model_reset();
    set_dut(0);

    // Reset values.
    cyc(1'b0, '0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    check_val("rst_data_i", 32'(dout_i[cur]), 32'd0);
    check_val("rst_data_q", 32'(dout_q[cur]), 32'd0);
    check_val("rst_phase", get_phase(), 32'd0);

    // P=2 ramp with constant request.
    rl_cnt = 0; dn_cnt = 0;
    run_frames(1, 1'b1, 16'd0, 0, 100, 1'b0);
    check_val("p2_ready_low_cycles", 32'(rl_cnt), 32'd8);
    check_val("p2_done_pulses", 32'(dn_cnt), 32'd1);

    // Alternating request during drain, random data and gaps.
    dn_cnt = 0;
    run_frames(1, 1'b0, 16'd0, 1, 70, 1'b0);
    check_val("toggle_done_pulses", 32'(dn_cnt), 32'd1);

    // Input held through drain, then a clean frame with the flag still set.
    run_frames(1, 1'b0, 16'd0, 0, 100, 1'b1);
    check_val("ovf_set", 32'(ovf[cur]), 32'd1);
    run_frames(1, 1'b1, 16'h0040, 2, 100, 1'b0);
    check_val("ovf_sticky", 32'(ovf[cur]), 32'd1);

    // Reset after three drained outputs, then a fresh ramp.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(200 + i), DW'(300 + i), 1'b1, 1'b0);
    drained_seen = 0;
    for (int k = 0; k < 50 && drained_seen < 3; k++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check_val("drain3_reached", 32'(drained_seen), 32'd3);
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check_val("midrst_data_i", 32'(dout_i[cur]), 32'd0);
    check_val("midrst_data_q", 32'(dout_q[cur]), 32'd0);
    check_val("midrst_phase", get_phase(), 32'd0);
    run_frames(1, 1'b1, 16'd100, 0, 100, 1'b0);

    // Back-to-back frames, next frame starts on the done pulse.
    dn_cnt = 0;
    run_frames(3, 1'b0, 16'd0, 0, 100, 1'b0);
    check_val("b2b_done_pulses", 32'(dn_cnt), 32'd3);

    // P=4.
    set_dut(1);
    do_reset();
    rl_cnt = 0; dn_cnt = 0;
    run_frames(1, 1'b1, 16'd0, 0, 100, 1'b0);
    check_val("p4_ready_low_cycles", 32'(rl_cnt), 32'd12);
    check_val("p4_done_pulses", 32'(dn_cnt), 32'd1);
    run_frames(2, 1'b0, 16'd0, 2, 80, 1'b0);

    // P=1 bypass.
    set_dut(2);
    do_reset();
    rl_cnt = 0; dn_cnt = 0;
    run_frames(1, 1'b1, 16'd0, 0, 100, 1'b0);
    check_val("p1_ready_low_cycles", 32'(rl_cnt), 32'd0);
    check_val("p1_done_pulses", 32'(dn_cnt), 32'd1);
    run_frames(2, 1'b0, 16'd0, 2, 60, 1'b0);

    check_val("model_queue_empty", 32'(bufq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decimate_buffer_to_sfft.md
Name: decimate_buffer_to_sfft

Overview:
- Parametrised successor to the even/odd splitter that feeds the streaming FFT (sFFT).
- Splits each NFFT-sample frame into P = 2^LOG2_PHASES decimation phases (sample n goes to phase n mod P).
- Phase 0 passes straight through while the frame loads. Phases 1..P-1 are buffered, then replayed phase by phase when the sFFT requests data.
- Adds input backpressure, phase tagging, frame-done and overflow reporting, and P=1 bypass.

Parameters:
- SIZE_BUFFER, 4, log2(NFFT). NFFT = 1<<SIZE_BUFFER.
- DATA_FFT_SIZE, 16, width of each I and Q sample.
- LOG2_PHASES, 1, log2(P). Legal range 0..SIZE_BUFFER-1. 0 means bypass.

Ports:
- i_clk, in, 1, single clock; all logic on its rising edge.
- i_reset, in, 1, synchronous, active-high reset.
- i_in_data_i, in, DATA_FFT_SIZE, input sample, I component.
- i_in_data_q, in, DATA_FFT_SIZE, input sample, Q component.
- i_valid, in, 1, input sample valid. A sample is accepted when i_valid & o_ready.
- o_ready, out, 1, block can accept input. High in LOAD, low in DRAIN.
- i_fft_wayt_data, in, 1, sFFT requests a buffered sample this cycle.
- o_out_data_i, out, DATA_FFT_SIZE, output sample, I component.
- o_out_data_q, out, DATA_FFT_SIZE, output sample, Q component.
- o_outvalid, out, 1, output sample valid.
- o_phase, out, max(LOG2_PHASES,1), phase index of the current output sample.
- o_frame_done, out, 1, one-cycle pulse after the last sample of a frame is output.
- o_overflow, out, 1, sticky flag: i_valid was asserted while o_ready was low.

Behaviour:
- Reset values: state=LOAD, sample counter n=0, read counter=0, o_ready=1, o_outvalid=0, o_phase=0, o_frame_done=0, o_overflow=0, output data registers=0.
- Reset mid-frame discards all buffered data. The next accepted sample is n=0.
- LOAD state:
  - Each accepted sample increments n, wrapping modulo NFFT.
  - Phase-0 samples are forwarded combinationally (0 latency): o_out_data = i_in_data, o_outvalid = 1, o_phase = 0.
  - Samples of phase p>0 write buffer address (p-1)*(NFFT/P) + (n>>LOG2_PHASES). For these, o_outvalid = 0.
  - Accepting n = NFFT-1 moves the state to DRAIN on the next cycle (P>1).
- DRAIN state:
  - o_ready = 0.
  - Each cycle with i_fft_wayt_data=1 issues a read at read counter r, then r increments. Reads are synchronous, so data appears on the registered outputs 1 cycle later with o_outvalid=1 and o_phase = 1 + r/(NFFT/P).
  - i_fft_wayt_data=0 stalls the read counter. o_outvalid is 0 on the following cycle.
  - After the last read (r = (P-1)*NFFT/P - 1) is issued, the state returns to LOAD in the same cycle as that sample's output.
  - o_frame_done pulses on the cycle after that last output. During that pulse o_ready=1, and a sample presented in that cycle is accepted as n=0.
- Output order: phase 0 in increasing n, then phase 1, ..., then phase P-1.
- Bypass (P=1): no buffer, state stays in LOAD, o_ready=1 always. Every accepted sample is forwarded. o_frame_done pulses the cycle after n=NFFT-1 is accepted.
- o_overflow: set when i_valid=1 and o_ready=0. It clears only on reset. The offered sample is dropped and n does not advance.
- i_fft_wayt_data in LOAD is ignored.
- Buffer depth is (P-1)*NFFT/P words of 2*DATA_FFT_SIZE bits. The read address never exceeds depth-1.

Decomposition:
- Shared package (sfft_pkg):
  - state encoding localparams LOAD/DRAIN;
  - a clog2 constant function;
  - derived constants NFFT, P, PHASE_LEN=NFFT/P, BUF_DEPTH.
- One sub-module, sfft_dp_buffer: simple dual-port RAM with one write port and one synchronous-read port. Parameters are depth and width. No reset on the memory array.
- The top level holds the FSM, the counters, the output mux and the flags.

Test Plan:
- NFFT=16, P=2, ramp 0..15 with i_valid=1 every cycle, i_fft_wayt_data=1 constant:
  - 0,2,...,14 appear at 0 latency with o_phase=0;
  - then 1,3,...,15 appear with o_phase=1, one per cycle;
  - o_frame_done pulses once, the cycle after 15;
  - o_ready is low for exactly 8 cycles.
- NFFT=16, P=4, ramp 0..15: output order 0,4,8,12, 1,5,9,13, 2,6,10,14, 3,7,11,15, with o_phase 0,1,2,3 per group.
- P=2 in DRAIN, i_fft_wayt_data toggling 1,0,1,0: outputs 1,3,5,... appear only on cycles following a request, with no duplicates or skips.
- i_valid held high through DRAIN: o_overflow rises on the first DRAIN cycle and stays high. The next frame still starts at n=0 and outputs correctly.
- Assert i_reset after 3 drained outputs: all outputs read 0 next cycle. The next ramp 100..115 produces only 100..115 values, with no stale data.
- Three back-to-back frames where i_valid is held during the o_frame_done pulse: the pulse-cycle sample is accepted as n=0, and three o_frame_done pulses are seen.
- LOG2_PHASES=0: ramp 0..15 passes through unchanged at 0 latency, o_ready is always 1, and o_frame_done pulses the cycle after 15.
